// File: rtl/mio_bus_responder.sv
// mio_bus_responder: slave side of the CPU memory/IO handshake.
// It latches one CPU request, decodes the address to data RAM, the LED register or the
// switch inputs, adds RAM wait states and answers with a one-cycle MIO_ready pulse.
// Optional feature: define MIO_BUS_ERR_EN to make bus_err a sticky unmapped-access flag.
// When the macro is not defined, bus_err is tied to 0.
module mio_bus_responder #(
    parameter int unsigned RAM_WAIT = 2,
    parameter int unsigned RAM_AW   = 10,
    parameter int unsigned LED_W    = 8,
    parameter int unsigned SW_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              CPU_MIO,
    input  logic              mem_w,
    input  logic [31:0]       addr_bus,
    input  logic [31:0]       Data_out,
    output logic [31:0]       Data_in,
    output logic              MIO_ready,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_we,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout,
    output logic [LED_W-1:0]  led,
    input  logic [SW_W-1:0]   sw,
    output logic              bus_err
);

    typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;
    typedef enum logic [1:0] {RegRam, RegLed, RegSw, RegNone} region_e;

    // Word addresses of the two I/O registers (byte address >> 2).
    localparam logic [29:0] LedWord  = 30'h3800_0000;
    localparam logic [29:0] SwWord   = 30'h3C00_0000;
    localparam logic [3:0]  WaitInit = 4'(RAM_WAIT - 1);

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    region_e            req_region;
    region_e            region_q;
    logic               we_q;
    logic [RAM_AW-1:0]  ram_addr_q;
    logic [31:0]        wdata_q;
    logic [LED_W-1:0]   led_q;
    logic [31:0]        data_in_q;

    logic               from_idle;
    region_e            cur_region;
    logic               cur_we;
    logic [LED_W-1:0]   led_wdata;
    logic [31:0]        rd_data;
    logic               ack_entry;

    // Word accesses only: the byte-lane bits carry no information.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^addr_bus[1:0];

    // Address decode of the live request (used only while idle).
    always_comb begin
        req_region = RegNone;
        if (addr_bus[31:12] == 20'h0_0000) begin
            req_region = RegRam;
        end else if (addr_bus[31:2] == LedWord) begin
            req_region = RegLed;
        end else if (addr_bus[31:2] == SwWord) begin
            req_region = RegSw;
        end
    end

    // I/O accesses go IDLE->ACK in one edge, before the latches are loaded, so the
    // completion logic looks at the live request when coming from IDLE.
    assign from_idle  = (state_q == StIdle);
    assign cur_region = from_idle ? req_region : region_q;
    assign cur_we     = from_idle ? mem_w : we_q;
    assign led_wdata  = from_idle ? Data_out[LED_W-1:0] : wdata_q[LED_W-1:0];

    // Next-state logic: IDLE latches, WAIT counts RAM wait states, ACK lasts one cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (CPU_MIO) begin
                    if (req_region == RegRam) begin
                        state_d = StWait;
                        cnt_d   = WaitInit;
                    end else begin
                        state_d = StAck;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StAck;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StAck: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 4'd0;
            end
        endcase
    end

    assign ack_entry = (state_q != StAck) && (state_d == StAck);

    // State and wait-counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request latch, loaded when a request is accepted in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            region_q   <= RegNone;
            we_q       <= 1'b0;
            ram_addr_q <= '0;
            wdata_q    <= 32'h0;
        end else if (from_idle && CPU_MIO) begin
            region_q   <= req_region;
            we_q       <= mem_w;
            ram_addr_q <= addr_bus[RAM_AW+1:2];
            wdata_q    <= Data_out;
        end
    end

    // Read-data source for the completing access; unmapped reads return zero.
    always_comb begin
        rd_data = 32'h0;
        case (cur_region)
            RegRam:  rd_data = ram_dout;
            RegLed:  rd_data = 32'(led_q);
            RegSw:   rd_data = 32'(sw);
            default: rd_data = 32'h0;
        endcase
    end

    // Read data and LED register update on entry to ACK; Data_in holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_in_q <= 32'h0;
            led_q     <= '0;
        end else if (ack_entry) begin
            if (!cur_we) begin
                data_in_q <= rd_data;
            end else if (cur_region == RegLed) begin
                led_q <= led_wdata;
            end
        end
    end

`ifdef MIO_BUS_ERR_EN
    logic bus_err_q;

    // Sticky flag, set when an unmapped access completes; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_err_q <= 1'b0;
        end else if (ack_entry && (cur_region == RegNone)) begin
            bus_err_q <= 1'b1;
        end
    end

    assign bus_err = bus_err_q;
`else
    assign bus_err = 1'b0;
`endif

    // RAM write strobe only in the first WAIT cycle.
    assign ram_we    = (state_q == StWait) && we_q && (cnt_q == WaitInit);
    assign ram_addr  = ram_addr_q;
    assign ram_din   = wdata_q;
    assign MIO_ready = (state_q == StAck);
    assign Data_in   = data_in_q;
    assign led       = led_q;

endmodule

// File: tb/tb_mio_bus_responder.sv
// Directed bench for mio_bus_responder with a synchronous RAM model and a scoreboard of
// expected completion pulses (cycle and read data).
module tb_mio_bus_responder;

    localparam int unsigned W = 2;

`ifdef MIO_BUS_ERR_EN
    localparam logic [31:0] ExpErr = 32'd1;
`else
    localparam logic [31:0] ExpErr = 32'd0;
`endif

    logic        clk;
    logic        rst_n;
    logic        CPU_MIO;
    logic        mem_w;
    logic [31:0] addr_bus;
    logic [31:0] Data_out;
    logic [31:0] Data_in;
    logic        MIO_ready;
    logic [9:0]  ram_addr;
    logic        ram_we;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;
    logic [7:0]  led;
    logic [7:0]  sw;
    logic        bus_err;

    mio_bus_responder #(
        .RAM_WAIT (W),
        .RAM_AW   (10),
        .LED_W    (8),
        .SW_W     (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .CPU_MIO   (CPU_MIO),
        .mem_w     (mem_w),
        .addr_bus  (addr_bus),
        .Data_out  (Data_out),
        .Data_in   (Data_in),
        .MIO_ready (MIO_ready),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout),
        .led       (led),
        .sw        (sw),
        .bus_err   (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM model with one-cycle read latency.
    logic [31:0] mem [1024];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       tag;
        int unsigned cyc;
        bit          chk;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_asserts = 0;
    int unsigned n_fail    = 0;
    int unsigned pulses    = 0;
    int unsigned we_cnt    = 0;
    logic [31:0] we_addr   = 32'h0;
    logic [31:0] we_data   = 32'h0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Monitor: every MIO_ready pulse must match the head of the scoreboard.
    exp_t mon_e;
    always @(negedge clk) begin
        if (ram_we === 1'b1) begin
            we_cnt++;
            we_addr = 32'(ram_addr);
            we_data = ram_din;
        end
        if (MIO_ready === 1'b1) begin
            pulses++;
            check("pulse_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check({mon_e.tag, "_cycle"}, 32'(cyc), 32'(mon_e.cyc));
                if (mon_e.chk) check({mon_e.tag, "_data"}, Data_in, mon_e.data);
            end
        end
    end

    function automatic int unsigned lat(input logic [31:0] a);
        return (a < 32'h0000_1000) ? W : 0;
    endfunction

    task automatic push(input string tag, input int unsigned c, input bit chk,
                        input logic [31:0] d);
        exp_t e;
        e.tag  = tag;
        e.cyc  = c;
        e.chk  = chk;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic wait_pulse(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (MIO_ready === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_ready"}, 32'(seen), 32'd1);
    endtask

    // One complete transaction; the pulse is expected W+1 cycles after sampling for RAM.
    task automatic req(input string tag, input logic we, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] exp_d);
        @(negedge clk);
        CPU_MIO  = 1'b1;
        mem_w    = we;
        addr_bus = a;
        Data_out = d;
        push(tag, cyc + 1 + lat(a), !we, exp_d);
        wait_pulse(tag);
        CPU_MIO = 1'b0;
        mem_w   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    int unsigned c0;
    int unsigned p0;
    int unsigned w0;

    initial begin
        rst_n    = 1'b0;
        CPU_MIO  = 1'b0;
        mem_w    = 1'b0;
        addr_bus = 32'h0;
        Data_out = 32'h0;
        sw       = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(MIO_ready), 32'd0);
        check("rst_data_in", Data_in, 32'h0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_led", 32'(led), 32'h0);
        check("rst_bus_err", 32'(bus_err), 32'd0);
        rst_n = 1'b1;

        // RAM write then read back at word 4.
        w0 = we_cnt;
        req("ram_wr", 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0);
        check("ram_we_count", we_cnt - w0, 32'd1);
        check("ram_we_addr", we_addr, 32'd4);
        check("ram_we_data", we_data, 32'hDEAD_BEEF);
        req("ram_rd", 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF);

        // LED write (upper data bits dropped) and read back.
        req("led_wr", 1'b1, 32'hE000_0000, 32'h1234_56A5, 32'h0);
        check("led_after_wr", 32'(led), 32'h0000_00A5);
        req("led_rd", 1'b0, 32'hE000_0000, 32'h0, 32'h0000_00A5);

        // Switch read; writing the switch address must not touch the LEDs.
        sw = 8'h3C;
        req("sw_rd", 1'b0, 32'hF000_0000, 32'h0, 32'h0000_003C);
        req("sw_wr", 1'b1, 32'hF000_0000, 32'h0000_005A, 32'h0);
        check("led_after_sw_wr", 32'(led), 32'h0000_00A5);

        // Three back-to-back RAM reads with CPU_MIO held high.
        req("pre20", 1'b1, 32'h0000_0020, 32'h1111_1111, 32'h0);
        req("pre24", 1'b1, 32'h0000_0024, 32'h2222_2222, 32'h0);
        req("pre28", 1'b1, 32'h0000_0028, 32'h3333_3333, 32'h0);
        @(negedge clk);
        c0       = cyc;
        p0       = pulses;
        CPU_MIO  = 1'b1;
        mem_w    = 1'b0;
        addr_bus = 32'h0000_0020;
        // Each access ends with one IDLE cycle, so pulses are W+2 cycles apart.
        push("b2b0", c0 + 1 + W, 1'b1, 32'h1111_1111);
        push("b2b1", c0 + 1 + W + (W + 2), 1'b1, 32'h2222_2222);
        push("b2b2", c0 + 1 + W + 2 * (W + 2), 1'b1, 32'h3333_3333);
        wait_pulse("b2b0");
        addr_bus = 32'h0000_0024;
        wait_pulse("b2b1");
        addr_bus = 32'h0000_0028;
        wait_pulse("b2b2");
        CPU_MIO = 1'b0;
        repeat (8) @(negedge clk);
        check("b2b_pulse_count", pulses - p0, 32'd3);

        // Reset during WAIT of a RAM write: no pulse, write aborted, state cleared.
        req("pre40", 1'b1, 32'h0000_0040, 32'h600D_F00D, 32'h0);
        @(negedge clk);
        CPU_MIO  = 1'b1;
        mem_w    = 1'b1;
        addr_bus = 32'h0000_0040;
        Data_out = 32'hBAAD_CAFE;
        @(negedge clk);
        rst_n   = 1'b0;
        CPU_MIO = 1'b0;
        mem_w   = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_ready", 32'(MIO_ready), 32'd0);
        check("abort_led", 32'(led), 32'h0);
        check("abort_data_in", Data_in, 32'h0);
        check("abort_ram_we", 32'(ram_we), 32'd0);
        rst_n = 1'b1;
        req("rd40", 1'b0, 32'h0000_0040, 32'h0, 32'h600D_F00D);
        req("rd10", 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF);

        // Unmapped accesses: read returns 0, write dropped, bus_err per build.
        req("led_wr2", 1'b1, 32'hE000_0000, 32'h0000_005A, 32'h0);
        check("bus_err_before", 32'(bus_err), 32'd0);
        req("unmap_rd", 1'b0, 32'h8000_0000, 32'h0, 32'h0);
        check("bus_err_set", 32'(bus_err), ExpErr);
        req("unmap_wr", 1'b1, 32'h8000_0000, 32'h0000_00FF, 32'h0);
        check("led_after_unmap_wr", 32'(led), 32'h0000_005A);
        req("led_rd2", 1'b0, 32'hE000_0000, 32'h0, 32'h0000_005A);
        repeat (3) @(negedge clk);
        check("bus_err_held", 32'(bus_err), ExpErr);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
